// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: byte-serial load/store on the 8-bit arbiter port, with pipeline stall and write-back.
// Define MEM_ALIGN_TRAP_EN to trap misaligned half/word accesses (adds misalign_o).
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mem_rd,
    input  logic              mem_wreg,
    input  logic [31:0]       mem_wdata,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_reg2,
    input  logic [1:0]        mem_sel,
    input  logic              mem_we,
    input  logic              load_sign,
    input  logic              memdone_rst,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o,
    output logic [7:0]        wdata_o,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    input  logic [7:0]        rdata_i,
    output logic [4:0]        wb_rd,
    output logic              wb_wreg,
    output logic [31:0]       wb_wdata,
    output logic              stallreq_o
`ifdef MEM_ALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_R, DONE, DRAIN} state_t;

    localparam logic [1:0] SEL_NOP  = 2'b00;
    localparam logic [1:0] SEL_BYTE = 2'b01;
    localparam logic [1:0] SEL_HALF = 2'b10;

    state_t      state;
    logic [1:0]  k;
    logic [1:0]  last_k;
    logic [1:0]  start_last_k;
    logic [31:0] rbuf;
    logic [31:0] sdata;
    logic        done;
    logic        flushed;
    logic        done_eff;

    // A memdone_rst pulse means the done flag belongs to the previous instruction.
    assign done_eff   = done & ~memdone_rst;
    assign stallreq_o = ~rst & (mem_sel != SEL_NOP) & ~done_eff;
    assign wb_rd      = mem_rd;

`ifdef MEM_ALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((mem_sel == SEL_HALF) & mem_addr[0]) |
                        ((mem_sel == 2'b11) & (mem_addr[1:0] != 2'b00));
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        start_last_k = 2'd3;
        if (mem_sel == SEL_BYTE) start_last_k = 2'd0;
        else if (mem_sel == SEL_HALF) start_last_k = 2'd1;

        wb_wreg = ~rst & mem_wreg & ((mem_sel == SEL_NOP) | mem_we | done_eff);
`ifdef MEM_ALIGN_TRAP_EN
        if (misalign_o & ~memdone_rst) wb_wreg = 1'b0;
`endif

        wb_wdata = mem_wdata;
        if (!mem_we && mem_sel != SEL_NOP && done_eff) begin
            case (mem_sel)
                SEL_BYTE: wb_wdata = {{24{load_sign & rbuf[7]}}, rbuf[7:0]};
                SEL_HALF: wb_wdata = {{16{load_sign & rbuf[15]}}, rbuf[15:0]};
                default:  wb_wdata = rbuf;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments in the block win.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            req_o   <= 1'b0;
            we_o    <= 1'b0;
            addr_o  <= '0;
            wdata_o <= '0;
            k       <= '0;
            last_k  <= '0;
            // NOTE: the read buffer is reset because wb_wdata can expose it.
            rbuf    <= '0;
            sdata   <= '0;
            done    <= 1'b0;
            flushed <= 1'b0;
`ifdef MEM_ALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
        end else begin
            if (memdone_rst) begin
                done <= 1'b0;
`ifdef MEM_ALIGN_TRAP_EN
                misalign_o <= 1'b0;
`endif
            end

            case (state)
                IDLE: begin
                    if (mem_sel != SEL_NOP && !done_eff) begin
                        k       <= '0;
                        last_k  <= start_last_k;
                        addr_o  <= mem_addr;
                        we_o    <= mem_we;
                        wdata_o <= mem_reg2[7:0];
                        sdata   <= {8'h00, mem_reg2[31:8]};
                        flushed <= 1'b0;
                        req_o   <= 1'b1;
                        state   <= REQ;
`ifdef MEM_ALIGN_TRAP_EN
                        if (misaligned) begin
                            req_o      <= 1'b0;
                            done       <= 1'b1;
                            misalign_o <= 1'b1;
                            state      <= DONE;
                        end
`endif
                    end
                end

                REQ: begin
                    if (we_o) begin
                        // A store that already wrote bytes must finish, but not mark the new instruction done.
                        if (memdone_rst && !gnt_i && k == 2'd0) begin
                            req_o <= 1'b0;
                            state <= IDLE;
                        end else begin
                            if (memdone_rst) flushed <= 1'b1;
                            if (gnt_i) begin
                                if (k == last_k) begin
                                    req_o <= 1'b0;
                                    state <= DONE;
                                    if (!flushed && !memdone_rst) done <= 1'b1;
                                end else begin
                                    k       <= k + 2'd1;
                                    addr_o  <= addr_o + ADDR_W'(1);
                                    wdata_o <= sdata[7:0];
                                    sdata   <= sdata >> 8;
                                end
                            end
                        end
                    end else if (memdone_rst) begin
                        req_o <= 1'b0;
                        state <= gnt_i ? DRAIN : IDLE;
                    end else if (gnt_i) begin
                        req_o <= 1'b0;
                        state <= WAIT_R;
                    end
                end

                WAIT_R: begin
                    if (memdone_rst) begin
                        state <= rvalid_i ? IDLE : DRAIN;
                    end else if (rvalid_i) begin
                        rbuf[{k, 3'b000} +: 8] <= rdata_i;
                        if (k == last_k) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            k      <= k + 2'd1;
                            addr_o <= addr_o + ADDR_W'(1);
                            req_o  <= 1'b1;
                            state  <= REQ;
                        end
                    end
                end

                DONE: begin
                    req_o <= 1'b0;
                    state <= IDLE;
                end

                DRAIN: begin
                    if (rvalid_i) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
